ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single asynchronous SRAM.
// Each port raises req with we/addr/wdata and holds it until ack. A winner is
// chosen in IDLE, its command is latched, and the RAM cycle is sequenced as
// SETUP -> STROBE -> HOLD -> DONE (write) or SETUP -> READ -> DONE (read).
// Every transaction returns to IDLE for one cycle before the next is sampled.
//
// Parameters:
//   SETUP_CYC  cycles the address is held before strobe/read sampling (1-15)
//   WRITE_CYC  cycles ram_write_n is held low (1-15)
//   READ_CYC   cycles from end of setup to read-data capture (1-15)
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   a_req/b_req               request, held until the matching ack
//   a_we/b_we                 1 = write, 0 = read
//   a_addr/b_addr             RAM address
//   a_wdata/b_wdata           write data
//   a_ack/b_ack               one-cycle completion pulse
//   a_rdata/b_rdata           registered read data, held until next read
//   busy                      high whenever not IDLE
//   ram_addr                  RAM address, stable from SETUP through DONE
//   ram_write_n               active-low RAM write enable
//   ram_data                  tri-state RAM data bus, driven in STROBE/HOLD
// Configuration:
//   RAM_ARB_ROUND_ROBIN_EN    when defined, a tie goes to the port that did not
//                             win the last transaction (A first after reset);
//                             otherwise A always wins a tie.
module ram_arbiter #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WRITE_CYC = 2,
  parameter int unsigned READ_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_we,
  input  logic       b_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] b_addr,
  input  logic [7:0] a_wdata,
  input  logic [7:0] b_wdata,
  output logic       a_ack,
  output logic       b_ack,
  output logic [7:0] a_rdata,
  output logic [7:0] b_rdata,
  output logic       busy,
  output logic [7:0] ram_addr,
  output logic       ram_write_n,
  inout  wire  [7:0] ram_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    READ,
    DONE
  } state_t;

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] WRITE_LOAD = 4'(WRITE_CYC - 1);
  localparam logic [3:0] READ_LOAD  = 4'(READ_CYC - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_load;
  logic       cnt_zero;
  logic       any_req;
  logic       pick_b;
  logic       grant_b;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       drive;

  assign any_req  = a_req | b_req;
  assign cnt_zero = (cnt == '0);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic prio_b;  // 1: B is preferred on the next tie

  assign pick_b = b_req & (~a_req | prio_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (state == IDLE && any_req) begin
      prio_b <= ~pick_b;
    end
  end
`else
  assign pick_b = b_req & ~a_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   if (cnt_zero) state_next = we_q ? STROBE : READ;
      STROBE:  if (cnt_zero) state_next = HOLD;
      HOLD:    state_next = DONE;
      READ:    if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reload value for the state being entered.
  always_comb begin
    cnt_load = '0;
    case (state_next)
      SETUP:   cnt_load = SETUP_LOAD;
      STROBE:  cnt_load = WRITE_LOAD;
      READ:    cnt_load = READ_LOAD;
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      grant_b  <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ram_addr <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      if (state_next != state) begin
        cnt <= cnt_load;
      end else if (!cnt_zero) begin
        cnt <= cnt - 4'd1;
      end

      if (state == IDLE && any_req) begin
        grant_b  <= pick_b;
        we_q     <= pick_b ? b_we    : a_we;
        wdata_q  <= pick_b ? b_wdata : a_wdata;
        ram_addr <= pick_b ? b_addr  : a_addr;
      end

      // Capture on the edge that leaves READ.
      if (state == READ && cnt_zero) begin
        if (grant_b) begin
          b_rdata <= ram_data;
        end else begin
          a_rdata <= ram_data;
        end
      end
    end
  end

  // Bus controls decode straight from the state register so that reset
  // releases the bus and deasserts the strobe without waiting for an edge.
  always_comb begin
    busy        = (state != IDLE);
    ram_write_n = (state != STROBE);
    drive       = (state == STROBE) || (state == HOLD);
    a_ack       = (state == DONE) && !grant_b;
    b_ack       = (state == DONE) && grant_b;
  end

  assign ram_data = drive ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_req, b_req, a_we, b_we;
  logic [7:0] a_addr, b_addr, a_wdata, b_wdata;
  logic       a_ack, b_ack, busy, ram_write_n;
  logic [7:0] a_rdata, b_rdata, ram_addr;
  wire  [7:0] ram_data;

  // Second instance with stretched timing, write-only, port B idle.
  logic       c_req, c_we;
  logic [7:0] c_addr, c_wdata;
  logic       c_ack, c_b_ack, c_busy, c_write_n;
  logic [7:0] c_rdata, c_b_rdata, c_ram_addr;
  wire  [7:0] c_data;
  logic       zero1;
  logic [7:0] zero8;

  // Simple RAM model: writes while ram_write_n is low, drives reads on request.
  logic [7:0] mem [256];
  logic       ram_oe;
  assign ram_data = ram_oe ? mem[ram_addr] : 'z;
  always @(posedge clk) if (ram_write_n === 1'b0) mem[ram_addr] <= ram_data;

  // Undriven buses read as 8'hFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (ram_data[i]);
    pullup (c_data[i]);
  end

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .busy(busy), .ram_addr(ram_addr), .ram_write_n(ram_write_n),
    .ram_data(ram_data)
  );

  ram_arbiter #(.SETUP_CYC(3), .WRITE_CYC(4), .READ_CYC(2)) dut_slow (
    .clk(clk), .rst(rst),
    .a_req(c_req), .b_req(zero1), .a_we(c_we), .b_we(zero1),
    .a_addr(c_addr), .b_addr(zero8), .a_wdata(c_wdata), .b_wdata(zero8),
    .a_ack(c_ack), .b_ack(c_b_ack), .a_rdata(c_rdata), .b_rdata(c_b_rdata),
    .busy(c_busy), .ram_addr(c_ram_addr), .ram_write_n(c_write_n),
    .ram_data(c_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic gw [4];   // 1 = grant to B
  int   gc [4];
  int   ng;
  int   acks;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; ram_oe = 1'b0;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    zero1 = 1'b0; zero8 = '0;

    step();
    chk("rst_busy", busy, 0);
    chk("rst_write_n", ram_write_n, 1);
    chk("rst_data", ram_data, 8'hFF);
    chk("rst_addr", ram_addr, 8'h00);
    chk("rst_acks", {a_ack, b_ack}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    @(negedge clk); rst = 1'b0;
    step();

    // A writes 0xA5 to 0x3C.
    a_req = 1; a_we = 1; a_addr = 8'h3C; a_wdata = 8'hA5;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("wr_write_n_c%0d", c), ram_write_n, (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("wr_data_c%0d", c), ram_data, (c >= 2 && c <= 4) ? 8'hA5 : 8'hFF);
      chk($sformatf("wr_a_ack_c%0d", c), a_ack, (c == 5) ? 1 : 0);
      chk($sformatf("wr_addr_c%0d", c), ram_addr, 8'h3C);
    end
    chk("wr_b_ack", b_ack, 0);
    a_req = 0;
    step();
    chk("wr_idle_busy", busy, 0);
    chk("wr_mem", mem[8'h3C], 8'hA5);

    // B reads 0x3C; bus must stay released by the arbiter.
    b_req = 1; b_we = 0; b_addr = 8'h3C; b_wdata = 8'h00;
    step();
    chk("rd_data_c1", ram_data, 8'hFF);
    chk("rd_write_n_c1", ram_write_n, 1);
    chk("rd_b_ack_c1", b_ack, 0);
    step();
    chk("rd_data_c2", ram_data, 8'hFF);
    chk("rd_b_ack_c2", b_ack, 0);
    ram_oe = 1;
    step();
    chk("rd_write_n_c3", ram_write_n, 1);
    chk("rd_b_ack_c3", b_ack, 0);
    chk("rd_rdata_early", b_rdata, 8'h00);
    step();
    ram_oe = 0;
    #1;
    chk("rd_b_ack_c4", b_ack, 1);
    chk("rd_a_ack_c4", a_ack, 0);
    chk("rd_b_rdata", b_rdata, 8'hA5);
    chk("rd_a_rdata", a_rdata, 8'h00);
    chk("rd_data_c4", ram_data, 8'hFF);
    b_req = 0;
    step();
    chk("rd_b_ack_c5", b_ack, 0);
    chk("rd_busy_c5", busy, 0);

    // Inputs change and req drops right after the sampling edge.
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h11;
    step();
    a_req = 0; a_addr = 8'h20; a_wdata = 8'h22;
    acks = 0;
    for (int c = 2; c <= 8; c++) begin
      step();
      if (a_ack) acks++;
      if (c == 2) chk("lat_data_c2", ram_data, 8'h11);
      if (c <= 5) chk($sformatf("lat_addr_c%0d", c), ram_addr, 8'h10);
      if (c == 5) chk("lat_a_ack_c5", a_ack, 1);
    end
    chk("lat_ack_count", acks, 1);
    chk("lat_mem_orig", mem[8'h10], 8'h11);
    chk("lat_mem_new", mem[8'h20], 8'h00);
    chk("lat_a_rdata", a_rdata, 8'h00);
    chk("lat_b_rdata", b_rdata, 8'hA5);

    // Reset during STROBE takes effect with no clock edge.
    a_req = 1; a_we = 1; a_addr = 8'h40; a_wdata = 8'h77;
    step();
    step();
    chk("ast_write_n_pre", ram_write_n, 0);
    chk("ast_data_pre", ram_data, 8'h77);
    #3;
    rst = 1'b1;
    #1;
    chk("ast_write_n", ram_write_n, 1);
    chk("ast_data", ram_data, 8'hFF);
    chk("ast_busy", busy, 0);
    chk("ast_addr", ram_addr, 8'h00);
    chk("ast_acks", {a_ack, b_ack}, 0);
    chk("ast_b_rdata", b_rdata, 8'h00);
    a_req = 0;
    @(negedge clk); rst = 1'b0;
    chk("ast_mem", mem[8'h40], 8'h00);

    // Both requests held: tie resolution, one IDLE bubble between grants.
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    a_addr = 8'h50; b_addr = 8'h60; a_wdata = 8'h5A; b_wdata = 8'h6B;
    ng = 0;
    for (int c = 1; c <= 40 && ng < 4; c++) begin
      step();
      if (a_ack || b_ack) begin
        chk($sformatf("tie_one_ack_%0d", ng), a_ack & b_ack, 0);
        gw[ng] = b_ack;
        gc[ng] = c;
        ng++;
        if (ng == 4) begin
          a_req = 0; b_req = 0;
        end
      end
    end
    chk("tie_grants", ng, 4);
    chk("tie_first_cycle", gc[0], 5);
    for (int i = 0; i < 4 && i < ng; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk($sformatf("tie_winner_%0d", i), gw[i], (i % 2 == 1) ? 1 : 0);
`else
      chk($sformatf("tie_winner_%0d", i), gw[i], 0);
`endif
      if (i > 0) chk($sformatf("tie_gap_%0d", i), gc[i] - gc[i-1], 6);
    end
    chk("tie_mem_a", mem[8'h50], 8'h5A);
    step();
    step();
    chk("tie_idle", busy, 0);

    // Stretched timing: SETUP_CYC=3, WRITE_CYC=4.
    c_req = 1; c_we = 1; c_addr = 8'h9A; c_wdata = 8'h3E;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) c_addr = 8'h00;
      chk($sformatf("slow_addr_c%0d", c), c_ram_addr, 8'h9A);
      chk($sformatf("slow_ack_c%0d", c), c_ack, (c == 9) ? 1 : 0);
      chk($sformatf("slow_write_n_c%0d", c), c_write_n, (c >= 4 && c <= 7) ? 0 : 1);
      chk($sformatf("slow_data_c%0d", c), c_data, (c >= 4 && c <= 8) ? 8'h3E : 8'hFF);
    end
    c_req = 0;
    step();
    chk("slow_idle", c_busy, 0);
    chk("slow_b_ack", c_b_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
